// File: rtl/bsg_cache_prefetch_pkg.sv
// Shared types for the prefetch/demand DMA arbiter.
// Holds the arbiter FSM encoding and the issue-counter ceiling.
package bsg_cache_prefetch_pkg;

    typedef enum logic [2:0] {
        e_idle,
        e_dem_send,
        e_dem_wait,
        e_pf_send,
        e_pf_wait
    } pf_arb_state_e;

    localparam logic [15:0] pf_count_max_lp = 16'hFFFF;

endpackage

// File: rtl/prefetch_dma_arbiter.sv
// Shares one DMA port between demand misses and a one-deep prefetch slot.
// Demand wins in IDLE; a demand to the pending prefetch address drops it.
module prefetch_dma_arbiter
    import bsg_cache_prefetch_pkg::*;
#(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    miss_dma_v_i,
    input  logic [addr_width_p-1:0] miss_dma_addr_i,
    output logic                    miss_dma_ready_o,
    output logic [data_width_p-1:0] miss_data_o,
    output logic                    miss_data_v_o,
    input  logic                    pf_req_i,
    input  logic [addr_width_p-1:0] pf_addr_i,
    output logic                    dma_busy_o,
    output logic [data_width_p-1:0] pf_data_o,
    output logic                    pf_data_v_o,
    output logic                    pf_drop_o,
    output logic                    dma_pkt_v_o,
    output logic [addr_width_p-1:0] dma_pkt_addr_o,
    input  logic                    dma_pkt_yumi_i,
    input  logic [data_width_p-1:0] dma_data_i,
    input  logic                    dma_data_v_i,
    output logic [15:0]             pf_issued_count_o
);

    pf_arb_state_e state_r, state_n;

    logic                    pf_pend_r;
    logic [addr_width_p-1:0] pf_addr_r;
    logic [addr_width_p-1:0] req_addr_r;
    logic [15:0]             pf_count_r;

    logic dem_accept;
    logic pf_launch;
    logic pf_inc;
    logic drop;

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= e_idle;
        else         state_r <= state_n;
    end

    // Next-state selection and per-state handshake outputs.
    always_comb begin
        state_n          = state_r;
        miss_dma_ready_o = 1'b0;
        dma_pkt_v_o      = 1'b0;
        miss_data_v_o    = 1'b0;
        pf_data_v_o      = 1'b0;
        dem_accept       = 1'b0;
        pf_launch        = 1'b0;
        pf_inc           = 1'b0;
        unique case (state_r)
            e_idle: begin
                miss_dma_ready_o = ~reset_i;
                if (miss_dma_v_i) begin
                    dem_accept = ~reset_i;
                    state_n    = e_dem_send;
                end else if (pf_pend_r) begin
                    pf_launch = 1'b1;
                    state_n   = e_pf_send;
                end
            end
            e_dem_send: begin
                dma_pkt_v_o = 1'b1;
                if (dma_pkt_yumi_i) state_n = e_dem_wait;
            end
            e_dem_wait: begin
                if (dma_data_v_i) begin
                    miss_data_v_o = 1'b1;
                    state_n       = e_idle;
                end
            end
            e_pf_send: begin
                dma_pkt_v_o = 1'b1;
                if (dma_pkt_yumi_i) begin
                    pf_inc  = 1'b1;
                    state_n = e_pf_wait;
                end
            end
            e_pf_wait: begin
                if (dma_data_v_i) begin
                    pf_data_v_o = 1'b1;
                    state_n     = e_idle;
                end
            end
            default: state_n = e_idle;
        endcase
    end

    assign drop = dem_accept & pf_pend_r & (miss_dma_addr_i == pf_addr_r);

    // Single prefetch slot: fills only when empty, empties on launch or drop.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pf_pend_r <= 1'b0;
            pf_addr_r <= '0;
        end else if (pf_launch | drop) begin
            pf_pend_r <= 1'b0;
        end else if (~pf_pend_r & pf_req_i) begin
            pf_pend_r <= 1'b1;
            pf_addr_r <= pf_addr_i;
        end
    end

    // Address presented to the DMA engine for the current transaction.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)         req_addr_r <= '0;
        else if (dem_accept) req_addr_r <= miss_dma_addr_i;
        else if (pf_launch)  req_addr_r <= pf_addr_r;
    end

    // Saturating count of prefetch packets taken by the DMA engine.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pf_count_r <= '0;
        end else if (pf_inc && pf_count_r != pf_count_max_lp) begin
            pf_count_r <= pf_count_r + 16'd1;
        end
    end

    assign dma_busy_o        = (state_r != e_idle) | pf_pend_r | miss_dma_v_i;
    assign pf_drop_o         = drop;
    assign dma_pkt_addr_o    = req_addr_r;
    assign miss_data_o       = miss_data_v_o ? dma_data_i : '0;
    assign pf_data_o         = pf_data_v_o ? dma_data_i : '0;
    assign pf_issued_count_o = pf_count_r;

endmodule

// File: tb/tb_prefetch_dma_arbiter.sv
// Directed scoreboard bench for prefetch_dma_arbiter.
// Expected DMA addresses and response data are queued as stimulus is driven.
module tb_prefetch_dma_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        miss_dma_v_i = 1'b0;
    logic [31:0] miss_dma_addr_i = '0;
    logic        miss_dma_ready_o;
    logic [31:0] miss_data_o;
    logic        miss_data_v_o;
    logic        pf_req_i = 1'b0;
    logic [31:0] pf_addr_i = '0;
    logic        dma_busy_o;
    logic [31:0] pf_data_o;
    logic        pf_data_v_o;
    logic        pf_drop_o;
    logic        dma_pkt_v_o;
    logic [31:0] dma_pkt_addr_o;
    logic        dma_pkt_yumi_i = 1'b0;
    logic [31:0] dma_data_i = '0;
    logic        dma_data_v_i = 1'b0;
    logic [15:0] pf_issued_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_miss_q[$];
    logic [31:0] exp_pf_q[$];

    prefetch_dma_arbiter #(.addr_width_p(32), .data_width_p(32)) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .miss_dma_v_i(miss_dma_v_i),
        .miss_dma_addr_i(miss_dma_addr_i),
        .miss_dma_ready_o(miss_dma_ready_o),
        .miss_data_o(miss_data_o),
        .miss_data_v_o(miss_data_v_o),
        .pf_req_i(pf_req_i),
        .pf_addr_i(pf_addr_i),
        .dma_busy_o(dma_busy_o),
        .pf_data_o(pf_data_o),
        .pf_data_v_o(pf_data_v_o),
        .pf_drop_o(pf_drop_o),
        .dma_pkt_v_o(dma_pkt_v_o),
        .dma_pkt_addr_o(dma_pkt_addr_o),
        .dma_pkt_yumi_i(dma_pkt_yumi_i),
        .dma_data_i(dma_data_i),
        .dma_data_v_i(dma_data_v_i),
        .pf_issued_count_o(pf_issued_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rsp(input logic [31:0] a);
        return (a == 32'h100) ? 32'hAA : {16'hCAFE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Plays the DMA engine for one transaction and scores both ends of it.
    task automatic serve(input bit is_pf);
        logic [31:0] ea;
        logic [31:0] ed;
        bit          seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dma_pkt_v_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            chk("pkt_timeout", 32'd0, 32'd1);
            return;
        end
        ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hDEAD;
        chk("pkt_addr", dma_pkt_addr_o, ea);
        dma_pkt_yumi_i = 1'b1;
        tick();
        dma_pkt_yumi_i = 1'b0;
        chk("wait_pkt_v", {31'd0, dma_pkt_v_o}, 32'd0);
        tick();
        chk("wait_busy", {31'd0, dma_busy_o}, 32'd1);
        dma_data_v_i = 1'b1;
        dma_data_i   = rsp(ea);
        #1;
        if (is_pf) begin
            ed = (exp_pf_q.size() != 0) ? exp_pf_q.pop_front() : 32'hDEAD;
            chk("pf_v", {31'd0, pf_data_v_o}, 32'd1);
            chk("pf_data", pf_data_o, ed);
            chk("pf_miss_v", {31'd0, miss_data_v_o}, 32'd0);
        end else begin
            ed = (exp_miss_q.size() != 0) ? exp_miss_q.pop_front() : 32'hDEAD;
            chk("miss_v", {31'd0, miss_data_v_o}, 32'd1);
            chk("miss_data", miss_data_o, ed);
            chk("miss_pf_v", {31'd0, pf_data_v_o}, 32'd0);
        end
        tick();
        dma_data_v_i = 1'b0;
        dma_data_i   = '0;
    endtask

    task automatic do_pf(input logic [31:0] a);
        pf_req_i  = 1'b1;
        pf_addr_i = a;
        exp_addr_q.push_back(a);
        exp_pf_q.push_back(rsp(a));
        tick();
        pf_req_i = 1'b0;
        serve(1'b1);
    endtask

    initial begin
        // reset, including demand-driven busy while held in reset
        tick();
        chk("rst_ready", {31'd0, miss_dma_ready_o}, 32'd0);
        chk("rst_pkt_v", {31'd0, dma_pkt_v_o}, 32'd0);
        chk("rst_busy", {31'd0, dma_busy_o}, 32'd0);
        chk("rst_count", {16'd0, pf_issued_count_o}, 32'd0);
        miss_dma_v_i = 1'b1;
        #1;
        chk("rst_busy_dem", {31'd0, dma_busy_o}, 32'd1);
        chk("rst_ready_dem", {31'd0, miss_dma_ready_o}, 32'd0);
        miss_dma_v_i = 1'b0;
        tick();
        reset_i = 1'b0;
        tick();
        chk("idle_ready", {31'd0, miss_dma_ready_o}, 32'd1);
        chk("idle_busy", {31'd0, dma_busy_o}, 32'd0);

        // plain demand miss
        miss_dma_v_i    = 1'b1;
        miss_dma_addr_i = 32'h100;
        exp_addr_q.push_back(32'h100);
        exp_miss_q.push_back(32'hAA);
        #1;
        chk("dem_busy", {31'd0, dma_busy_o}, 32'd1);
        tick();
        miss_dma_v_i = 1'b0;
        chk("dem_lat1", {31'd0, dma_pkt_v_o}, 32'd1);
        chk("send_ready", {31'd0, miss_dma_ready_o}, 32'd0);
        dma_data_v_i = 1'b1;
        dma_data_i   = 32'h55;
        #1;
        chk("send_ign_v", {31'd0, miss_data_v_o}, 32'd0);
        chk("send_ign_d", miss_data_o, 32'd0);
        dma_data_v_i = 1'b0;
        dma_data_i   = '0;
        serve(1'b0);
        chk("dem_done_d", miss_data_o, 32'd0);
        chk("dem_done_busy", {31'd0, dma_busy_o}, 32'd0);

        // lone prefetch; a second pulse while the slot is full is ignored
        pf_req_i  = 1'b1;
        pf_addr_i = 32'h140;
        exp_addr_q.push_back(32'h140);
        exp_pf_q.push_back(rsp(32'h140));
        tick();
        chk("pf_busy", {31'd0, dma_busy_o}, 32'd1);
        chk("pf_pend_pkt", {31'd0, dma_pkt_v_o}, 32'd0);
        pf_addr_i = 32'h180;
        tick();
        pf_req_i = 1'b0;
        serve(1'b1);
        chk("pf_count1", {16'd0, pf_issued_count_o}, 32'd1);
        tick();
        chk("pf_ign_pkt", {31'd0, dma_pkt_v_o}, 32'd0);
        chk("pf_ign_busy", {31'd0, dma_busy_o}, 32'd0);

        // demand and prefetch together: demand goes first
        pf_req_i        = 1'b1;
        pf_addr_i       = 32'h140;
        miss_dma_v_i    = 1'b1;
        miss_dma_addr_i = 32'h100;
        exp_addr_q.push_back(32'h100);
        exp_miss_q.push_back(32'hAA);
        exp_addr_q.push_back(32'h140);
        exp_pf_q.push_back(rsp(32'h140));
        tick();
        pf_req_i     = 1'b0;
        miss_dma_v_i = 1'b0;
        serve(1'b0);
        chk("prio_pend", {31'd0, dma_busy_o}, 32'd1);
        serve(1'b1);
        chk("pf_count2", {16'd0, pf_issued_count_o}, 32'd2);

        // demand arriving during PF_SEND waits for IDLE
        pf_req_i  = 1'b1;
        pf_addr_i = 32'h180;
        exp_addr_q.push_back(32'h180);
        exp_pf_q.push_back(rsp(32'h180));
        exp_addr_q.push_back(32'h1C0);
        exp_miss_q.push_back(rsp(32'h1C0));
        tick();
        pf_req_i = 1'b0;
        tick();
        miss_dma_v_i    = 1'b1;
        miss_dma_addr_i = 32'h1C0;
        #1;
        chk("nopreempt_rdy", {31'd0, miss_dma_ready_o}, 32'd0);
        serve(1'b1);
        chk("late_dem_rdy", {31'd0, miss_dma_ready_o}, 32'd1);
        tick();
        miss_dma_v_i = 1'b0;
        serve(1'b0);
        chk("pf_count3", {16'd0, pf_issued_count_o}, 32'd3);

        // demand to the pending prefetch address drops the prefetch
        pf_req_i  = 1'b1;
        pf_addr_i = 32'h140;
        tick();
        pf_req_i        = 1'b0;
        miss_dma_v_i    = 1'b1;
        miss_dma_addr_i = 32'h140;
        exp_addr_q.push_back(32'h140);
        exp_miss_q.push_back(rsp(32'h140));
        #1;
        chk("drop_pulse", {31'd0, pf_drop_o}, 32'd1);
        tick();
        miss_dma_v_i = 1'b0;
        chk("drop_end", {31'd0, pf_drop_o}, 32'd0);
        serve(1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("drop_nopkt", {31'd0, dma_pkt_v_o}, 32'd0);
            tick();
        end
        chk("drop_busy", {31'd0, dma_busy_o}, 32'd0);
        chk("drop_count", {16'd0, pf_issued_count_o}, 32'd3);

        // reset in DEM_WAIT, then late data is ignored
        miss_dma_v_i    = 1'b1;
        miss_dma_addr_i = 32'h200;
        tick();
        miss_dma_v_i   = 1'b0;
        dma_pkt_yumi_i = 1'b1;
        tick();
        dma_pkt_yumi_i = 1'b0;
        reset_i        = 1'b1;
        #1;
        chk("arst_busy", {31'd0, dma_busy_o}, 32'd0);
        chk("arst_count", {16'd0, pf_issued_count_o}, 32'd0);
        tick();
        reset_i      = 1'b0;
        dma_data_v_i = 1'b1;
        dma_data_i   = 32'h77;
        #1;
        chk("late_miss_v", {31'd0, miss_data_v_o}, 32'd0);
        chk("late_miss_d", miss_data_o, 32'd0);
        chk("late_ready", {31'd0, miss_dma_ready_o}, 32'd1);
        chk("late_addr", dma_pkt_addr_o, 32'd0);
        tick();
        dma_data_v_i = 1'b0;
        dma_data_i   = '0;
        chk("late_idle", {31'd0, dma_busy_o}, 32'd0);

        // counting, then saturation from just below the ceiling
        for (int i = 0; i < 4; i++) do_pf(32'h1000 + 32'(i * 64));
        chk("count4", {16'd0, pf_issued_count_o}, 32'd4);
        force dut.pf_count_r = 16'hFFFD;
        tick();
        release dut.pf_count_r;
        tick();
        chk("preset", {16'd0, pf_issued_count_o}, 32'hFFFD);
        do_pf(32'h2000);
        chk("count_fffe", {16'd0, pf_issued_count_o}, 32'hFFFE);
        do_pf(32'h2040);
        chk("count_ffff", {16'd0, pf_issued_count_o}, 32'hFFFF);
        do_pf(32'h2080);
        chk("count_sat", {16'd0, pf_issued_count_o}, 32'hFFFF);

        chk("q_addr_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("q_miss_empty", 32'(exp_miss_q.size()), 32'd0);
        chk("q_pf_empty", 32'(exp_pf_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prefetch_dma_arbiter.md
PREFETCH_DMA_ARBITER -- requirements
Module: prefetch_dma_arbiter

Interface
REQ-001 SHALL have parameter addr_width_p, default 32: width of all address ports.
REQ-002 SHALL have parameter data_width_p, default 32: width of all data ports.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port miss_dma_v_i  input  1  demand-miss DMA request valid.
REQ-006 SHALL have port miss_dma_addr_i  input  addr_width_p  demand-miss address.
REQ-007 SHALL have port miss_dma_ready_o  output  1  demand request accepted when high with miss_dma_v_i.
REQ-008 SHALL have port miss_data_o / miss_data_v_o  output  data_width_p / 1  demand response data and valid.
REQ-009 SHALL have port pf_req_i / pf_addr_i  input  1 / addr_width_p  one-cycle prefetch request pulse and address.
REQ-010 SHALL have port dma_busy_o  output  1  high when no new prefetch can be accepted.
REQ-011 SHALL have port pf_data_o / pf_data_v_o  output  data_width_p / 1  prefetch response data and valid.
REQ-012 SHALL have port pf_drop_o  output  1  one-cycle pulse when a pending prefetch is discarded.
REQ-013 SHALL have port dma_pkt_v_o / dma_pkt_addr_o  output  1 / addr_width_p  request to the DMA engine.
REQ-014 SHALL have port dma_pkt_yumi_i  input  1  DMA engine accepts the presented request.
REQ-015 SHALL have port dma_data_i / dma_data_v_i  input  data_width_p / 1  DMA response data and valid.
REQ-016 SHALL have port pf_issued_count_o  output  16  saturating count of prefetches accepted by DMA.

Function
REQ-017 SHALL implement FSM states IDLE, DEM_SEND, DEM_WAIT, PF_SEND, PF_WAIT.
REQ-018 SHALL hold one pending-prefetch slot (pf_pend_r, pf_addr_r); pf_req_i captured only when slot empty, otherwise ignored.
REQ-019 SHALL drive dma_busy_o = (state != IDLE) | pf_pend_r | miss_dma_v_i, combinationally.
REQ-020 SHALL drive miss_dma_ready_o high only in IDLE; acceptance latches miss_dma_addr_i into req_addr_r and goes to DEM_SEND.
REQ-021 SHALL give demand priority: in IDLE with miss_dma_v_i and pf_pend_r both high, demand is accepted and prefetch stays pending.
REQ-022 SHALL discard the pending prefetch (clear slot, pulse pf_drop_o) when an accepted demand address equals pf_addr_r.
REQ-023 SHALL in IDLE with no demand and pf_pend_r high: copy pf_addr_r to req_addr_r, clear slot, go to PF_SEND.
REQ-024 SHALL in DEM_SEND/PF_SEND hold dma_pkt_v_o=1, dma_pkt_addr_o=req_addr_r; on dma_pkt_yumi_i go to DEM_WAIT/PF_WAIT.
REQ-025 SHALL not preempt PF_SEND; a demand arriving then waits (ready low) until return to IDLE.
REQ-026 SHALL in DEM_WAIT on dma_data_v_i assert miss_data_v_o with miss_data_o=dma_data_i same cycle, go to IDLE.
REQ-027 SHALL in PF_WAIT on dma_data_v_i assert pf_data_v_o with pf_data_o=dma_data_i same cycle, go to IDLE.
REQ-028 SHALL ignore dma_data_v_i in IDLE/DEM_SEND/PF_SEND; data outputs zero when their valid is low.
REQ-029 SHALL increment pf_issued_count_o on PF_SEND with yumi, saturating at 16'hFFFF.
REQ-030 SHALL have minimum latency demand accept to dma_pkt_v_o of one cycle.

Reset
REQ-031 SHALL on reset_i: state IDLE, slot empty, req_addr_r 0, counter 0; all outputs 0 except dma_busy_o which follows REQ-019 (0 when miss_dma_v_i low).
REQ-032 SHALL on reset mid-transaction discard the in-flight request; a later dma_data_v_i is ignored per REQ-028.

Structure
REQ-033 SHALL place the FSM state enum in shared package bsg_cache_prefetch_pkg.
REQ-034 SHALL be a single module with no sub-modules.

Verification
REQ-035 Demand 0x100, yumi next cycle, data 0xAA two cycles later -> miss_data_v_o=1, miss_data_o=0xAA, pf_data_v_o=0.
REQ-036 Prefetch 0x140 while idle -> dma_busy_o=1 next cycle, dma_pkt_addr_o=0x140, pf_data_v_o with data, count=1.
REQ-037 Prefetch 0x140 pending plus demand 0x100 same cycle -> demand issued first, then 0x140.
REQ-038 Pending prefetch 0x140 then demand 0x140 -> pf_drop_o pulse, only one DMA request, count unchanged.
REQ-039 reset_i asserted in DEM_WAIT, then dma_data_v_i -> no miss_data_v_o, state IDLE.
REQ-040 65536 prefetches accepted -> pf_issued_count_o holds 16'hFFFF.
